ym_slot_cnt_ring: RTL



---
 rtl/ym_slot_cnt_ring.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ym_slot_cnt_ring.sv
`default_nettype none
// ============================================================================
// Module   : ym_slot_cnt_ring
// Purpose  : Time-multiplexed per-slot counter bank. CHANNELS counters of
//            DATA_WIDTH bits recirculate through a two-phase (c1/c2)
//            master/slave ring. The head slot is cleared, loaded or stepped
//            each slot period, in wrap or saturate mode. Also produces the
//            index of the slot at the head and a sync strobe for slot 0.
// Options  : YM_SLOT_CNT_DBG_EN - when defined, dbg_val snapshots cur_val on
//            the c2 edge of the slot selected by dbg_sel. When undefined,
//            dbg_val is tied to zero and no storage is built.
// Revision : 1.0 - initial release
// ============================================================================
module ym_slot_cnt_ring #(
  parameter  int CHANNELS   = 24,
  parameter  int DATA_WIDTH = 10,
  parameter  int STEP_WIDTH = 4,
  parameter  int SATURATE   = 0,
  localparam int SLOT_W     = $clog2(CHANNELS)
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] cur_val,
  output logic [DATA_WIDTH-1:0] next_val,
  output logic                  c_out,
  output logic [SLOT_W-1:0]     slot,
  output logic                  sync,
  input  logic [SLOT_W-1:0]     dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_val
);

  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(CHANNELS - 1);

  logic [DATA_WIDTH-1:0] r_master [CHANNELS];
  logic [DATA_WIDTH-1:0] r_slave  [CHANNELS];
  logic [SLOT_W-1:0]     r_slot;

  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_add;

  // The last slave is transparent while c2 is high, so the head value seen by
  // the adder already reflects the transfer happening on this edge.
  assign cur_val = c2 ? r_master[CHANNELS-1] : r_slave[CHANNELS-1];

  // Load replaces the recirculated value as the add operand; step is
  // zero-extended and the extra MSB captures the carry.
  assign w_base = load ? load_val : cur_val;
  assign w_sum  = {1'b0, w_base} + (DATA_WIDTH + 1)'(step);

  generate
    if (SATURATE != 0) begin : g_sat
      assign w_add = w_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
    end else begin : g_wrap
      assign w_add = w_sum[DATA_WIDTH-1:0];
    end
  endgenerate

  // Clear overrides both load and add, and suppresses the carry.
  assign next_val = clr ? '0   : w_add;
  assign c_out    = clr ? 1'b0 : w_sum[DATA_WIDTH];

  assign slot = r_slot;
  assign sync = (r_slot == '0);

  // Ring stages: c1 captures into masters (head gets the write-back value),
  // c2 moves every master into its slave. Both phases read pre-edge values,
  // so a value never crosses two stages on one edge.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_master[i] <= '0;
        r_slave[i]  <= '0;
      end
    end else begin
      if (c1) begin
        r_master[0] <= next_val;
        for (int i = 1; i < CHANNELS; i++) begin
          r_master[i] <= r_slave[i-1];
        end
      end
      if (c2) begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_slave[i] <= r_master[i];
        end
      end
    end
  end

  // Slot index advances with each c2 transfer and wraps after the last slot.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else if (c2) begin
      r_slot <= (r_slot == c_last_slot) ? '0 : r_slot + 1'b1;
    end
  end

`ifdef YM_SLOT_CNT_DBG_EN
  logic [DATA_WIDTH-1:0] r_dbg;

  // Snapshot the head value on the c2 edge of the selected slot; a select
  // beyond the last slot can never equal r_slot and so never captures.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_dbg <= '0;
    end else if (c2 && (r_slot == dbg_sel)) begin
      r_dbg <= cur_val;
    end
  end

  assign dbg_val = r_dbg;
`else
  logic w_unused_dbg;

  assign w_unused_dbg = ^dbg_sel;
  assign dbg_val      = '0;
`endif

endmodule
`default_nettype wire
